// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states and
// bit positions of the status flags inside a packed flag vector.
package alu_pkg;

   // Opcodes carried on Sel
   localparam logic [2:0] OP_MUL = 3'd0;
   localparam logic [2:0] OP_SRL = 3'd1;
   localparam logic [2:0] OP_XOR = 3'd2;
   localparam logic [2:0] OP_ADD = 3'd3;
   localparam logic [2:0] OP_SUB = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_AND = 3'd6;
   localparam logic [2:0] OP_SHL = 3'd7;

   // Control FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } alu_state_t;

   // Flag positions within a packed status vector
   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_CARRY = 1;
   localparam int FLAG_NEG   = 2;
   localparam int FLAG_OVF   = 3;
   localparam int FLAG_W     = 4;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier. One multiplier bit is consumed
// per step; o_finish flags that the step about to be taken is the last one,
// so the controller can leave its MUL state on that same edge.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_load,
   input  logic               i_step,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_finish,
   output logic [2*WIDTH-1:0] o_product
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic [CW-1:0]      r_count;
   logic [2*WIDTH-1:0] w_partial;

   // Multiplicand weighted by the current iteration index
   assign w_partial = r_mcand << r_count;

   // Load operands, then accumulate one partial product per step
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_count  <= '0;
      end else if (i_load) begin
         r_mcand  <= {{WIDTH{1'b0}}, i_a};
         r_mplier <= i_b;
         r_acc    <= '0;
         r_count  <= '0;
      end else if (i_step) begin
         if (r_mplier[0]) begin
            r_acc <= r_acc + w_partial;
         end
         r_mplier <= r_mplier >> 1;
         r_count  <= r_count + CW'(1);
      end
   end

   assign o_finish  = (r_count == CW'(WIDTH - 1));
   assign o_product = r_acc;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU for the execute stage. Operands are captured on an
// accepted start; single-cycle ops commit one edge later, MUL iterates
// through alu_mul_iter. Out and flags only change on the commit edge.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [2:0]         Sel,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] Out,
   output logic               zero_flag,
   output logic               carry_flag,
   output logic               neg_flag,
   output logic               ovf_flag
);

   localparam int W2 = 2 * WIDTH;
   // Shift amounts at or above the result width flush everything out
   localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(W2);

   alu_state_t        r_state;
   alu_state_t        w_state_next;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [2:0]        r_sel;
   logic              r_done;
   logic [W2-1:0]     r_out;
   logic [FLAG_W-1:0] r_flags;

   logic              w_accept;
   logic              w_mul_load;
   logic              w_mul_step;
   logic              w_mul_finish;
   logic              w_commit;
   logic [W2-1:0]     w_product;

   logic [W2-1:0]     w_ext_a;
   logic [W2-1:0]     w_ext_b;
   logic [W2-1:0]     w_sum;
   logic [W2-1:0]     w_diff;
   logic [2*W2-1:0]   w_shl_wide;
   logic              w_sh_big;
   logic [W2-1:0]     w_result;
   logic              w_carry;
   logic              w_ovf;
   logic [FLAG_W-1:0] w_flags;

   alu_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_mul_load),
      .i_step    (w_mul_step),
      .i_a       (A),
      .i_b       (B),
      .o_finish  (w_mul_finish),
      .o_product (w_product)
   );

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and control strobes; a start during the done pulse is dropped
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_mul_load   = 1'b0;
      w_mul_step   = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && !r_done) begin
               w_accept = 1'b1;
               if (Sel == OP_MUL) begin
                  w_mul_load   = 1'b1;
                  w_state_next = MUL;
               end else begin
                  w_state_next = DONE;
               end
            end
         end
         MUL: begin
            w_mul_step = 1'b1;
            if (w_mul_finish) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            w_commit     = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign w_ext_a    = {{WIDTH{1'b0}}, r_a};
   assign w_ext_b    = {{WIDTH{1'b0}}, r_b};
   assign w_sum      = w_ext_a + w_ext_b;
   assign w_diff     = w_ext_a - w_ext_b;
   assign w_shl_wide = {{W2{1'b0}}, w_ext_a} << r_b;
   assign w_sh_big   = (r_b >= SH_LIM);

   // Single-cycle datapath and flag generation from the latched operands
   always_comb begin
      w_result = '0;
      w_carry  = 1'b0;
      w_ovf    = 1'b0;
      case (r_sel)
         OP_MUL: w_result = w_product;
         OP_SRL: w_result = w_sh_big ? '0 : (w_ext_a >> r_b);
         OP_XOR: w_result = w_ext_a ^ w_ext_b;
         OP_ADD: begin
            w_result = w_sum;
            w_carry  = w_sum[WIDTH];
            w_ovf    = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_SUB: begin
            w_result = w_diff;
            w_carry  = (r_a < r_b);
            w_ovf    = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_OR:  w_result = w_ext_a | w_ext_b;
         OP_AND: w_result = w_ext_a & w_ext_b;
         OP_SHL: begin
            w_result = w_sh_big ? '0 : w_shl_wide[W2-1:0];
            w_carry  = w_sh_big ? (|r_a) : (|w_shl_wide[2*W2-1:W2]);
         end
         default: w_result = '0;
      endcase
      w_flags             = '0;
      w_flags[FLAG_ZERO]  = (w_result == '0);
      w_flags[FLAG_CARRY] = w_carry;
      w_flags[FLAG_NEG]   = w_result[W2-1];
      w_flags[FLAG_OVF]   = w_ovf;
   end

   // Operand capture, done pulse, and result/flag commit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sel   <= '0;
         r_done  <= 1'b0;
         r_out   <= '0;
         r_flags <= '0;
      end else begin
         r_done <= w_commit;
         if (w_accept) begin
            r_a   <= A;
            r_b   <= B;
            r_sel <= Sel;
         end
         if (w_commit) begin
            r_out   <= w_result;
            r_flags <= w_flags;
         end
      end
   end

   assign busy       = (r_state != IDLE);
   assign done       = r_done;
   assign Out        = r_out;
   assign zero_flag  = r_flags[FLAG_ZERO];
   assign carry_flag = r_flags[FLAG_CARRY];
   assign neg_flag   = r_flags[FLAG_NEG];
   assign ovf_flag   = r_flags[FLAG_OVF];

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=32): expected results are pushed to a
// scoreboard at issue time and popped when the DUT pulses done.
module tb_alu_mc;

   localparam int WIDTH = 32;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  sel;
   logic        busy;
   logic        done;
   logic [63:0] out;
   logic        zf;
   logic        cf;
   logic        nf;
   logic        vf;

   typedef struct packed {
      logic [63:0] out;
      logic        z;
      logic        c;
      logic        n;
      logic        v;
   } exp_t;

   typedef struct {
      string tag;
      exp_t  e;
      int    lat;
   } sb_t;

   sb_t sbq[$];
   int  checks = 0;
   int  errors = 0;

   alu_mc #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .A          (a),
      .B          (b),
      .Sel        (sel),
      .busy       (busy),
      .done       (done),
      .Out        (out),
      .zero_flag  (zf),
      .carry_flag (cf),
      .neg_flag   (nf),
      .ovf_flag   (vf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model of one operation
   function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] isel);
      exp_t   e;
      longint sa;
      longint sbv;
      longint r;
      e   = '0;
      sa  = longint'($signed(ia));
      sbv = longint'($signed(ib));
      case (isel)
         3'd0: e.out = 64'(ia) * 64'(ib);
         3'd1: begin
            for (int i = 0; i < 32; i++) begin
               if (ia[i] && longint'(ib) <= longint'(i)) e.out[i - int'(ib)] = 1'b1;
            end
         end
         3'd2: e.out = 64'(ia ^ ib);
         3'd3: begin
            e.out = 64'(ia) + 64'(ib);
            e.c   = (e.out > 64'h0000_0000_FFFF_FFFF);
            r     = sa + sbv;
            e.v   = (r > longint'(32'sh7FFFFFFF)) || (r < longint'(32'sh80000000));
         end
         3'd4: begin
            e.out = 64'(ia) - 64'(ib);
            e.c   = (ia < ib);
            r     = sa - sbv;
            e.v   = (r > longint'(32'sh7FFFFFFF)) || (r < longint'(32'sh80000000));
         end
         3'd5: e.out = 64'(ia | ib);
         3'd6: e.out = 64'(ia & ib);
         default: begin
            for (int i = 0; i < 32; i++) begin
               if (ia[i]) begin
                  if (longint'(i) + longint'(ib) < 64) e.out[i + int'(ib)] = 1'b1;
                  else e.c = 1'b1;
               end
            end
         end
      endcase
      e.z = (e.out == 64'd0);
      e.n = e.out[63];
      return e;
   endfunction

   // Drive one start pulse; returns at the negedge after the accepting edge
   task automatic issue(input string tag, input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] isel);
      sb_t item;
      @(negedge clk);
      a     = ia;
      b     = ib;
      sel   = isel;
      start = 1'b1;
      item.tag = tag;
      item.e   = model(ia, ib, isel);
      item.lat = (isel == 3'd0) ? WIDTH + 1 : 1;
      sbq.push_back(item);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy"}, 64'(busy), 64'd1);
   endtask

   // Wait (bounded) for done, then pop and compare; returns in the done cycle
   task automatic wait_done(input int cyc0);
      sb_t item;
      int  cyc;
      cyc = cyc0;
      while (done !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
         item = sbq.pop_front();
         chk({item.tag, "_lat"}, 64'(cyc), 64'(item.lat));
         chk({item.tag, "_out"}, out, item.e.out);
         chk({item.tag, "_flags_zcnv"}, 64'({zf, cf, nf, vf}),
             64'({item.e.z, item.e.c, item.e.n, item.e.v}));
         chk({item.tag, "_busy_at_done"}, 64'(busy), 64'd0);
      end
   endtask

   initial begin
      int          seen;
      logic [2:0]  rs;
      logic [31:0] ra;
      logic [31:0] rb;

      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      sel   = '0;
      repeat (3) @(negedge clk);
      chk("rst_out", out, 64'd0);
      chk("rst_flags", 64'({zf, cf, nf, vf}), 64'd0);
      chk("rst_busy_done", 64'({busy, done}), 64'd0);
      reset = 1'b0;

      issue("add_carry", 32'hFFFF_FFFF, 32'd1, 3'd3);
      wait_done(0);

      // start during the done cycle must be ignored
      start = 1'b1;
      a     = 32'd5;
      b     = 32'd5;
      sel   = 3'd3;
      @(negedge clk);
      start = 1'b0;
      chk("restart_in_done_busy", 64'(busy), 64'd0);
      chk("done_one_cycle", 64'(done), 64'd0);
      @(negedge clk);
      chk("restart_in_done_nodone", 64'(done), 64'd0);
      chk("out_held", out, 64'h0000_0001_0000_0000);

      issue("sub_borrow", 32'd3, 32'd5, 3'd4);
      wait_done(0);
      // back-to-back: restart in the cycle right after done
      issue("sub_equal", 32'd7, 32'd7, 3'd4);
      wait_done(0);
      issue("add_ovf", 32'h7FFF_FFFF, 32'd1, 3'd3);
      wait_done(0);
      issue("sub_ovf", 32'h8000_0000, 32'd1, 3'd4);
      wait_done(0);
      issue("xor", 32'hF0F0_A5A5, 32'h0FF0_FFFF, 3'd2);
      wait_done(0);
      issue("or", 32'h1200_0034, 32'h0056_7800, 3'd5);
      wait_done(0);
      issue("and", 32'hDEAD_BEEF, 32'hFFFF_0000, 3'd6);
      wait_done(0);
      issue("shl_carry", 32'h8000_0001, 32'd33, 3'd7);
      wait_done(0);
      issue("shl_small", 32'h1234_5678, 32'd4, 3'd7);
      wait_done(0);
      issue("srl_31", 32'h8000_0000, 32'd31, 3'd1);
      wait_done(0);
      issue("srl_64", 32'h8000_0000, 32'd64, 3'd1);
      wait_done(0);

      // long MUL with a start attempt mid-flight
      issue("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0);
      repeat (5) @(negedge clk);
      chk("mid_mul_out_held", out, 64'd0);
      chk("mid_mul_zero_held", 64'(zf), 64'd1);
      start = 1'b1;
      a     = 32'd1;
      b     = 32'd2;
      sel   = 3'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done(6);
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("ignored_start_no_done", 64'(seen), 64'd0);

      issue("mul_small", 32'd3, 32'd5, 3'd0);
      wait_done(0);
      issue("mul_zero", 32'h1234_5678, 32'd0, 3'd0);
      wait_done(0);

      for (int i = 0; i < 6; i++) begin
         rs = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = (rs == 3'd1 || rs == 3'd7) ? 32'($urandom_range(0, 70)) : $urandom;
         issue("rnd", ra, rb, rs);
         wait_done(0);
      end

      // reset in the middle of a MUL
      issue("sub_pre_rst", 32'd3, 32'd5, 3'd4);
      wait_done(0);
      issue("mul_abort", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_out", out, 64'd0);
      chk("abort_flags", 64'({zf, cf, nf, vf}), 64'd0);
      chk("abort_busy_done", 64'({busy, done}), 64'd0);
      sbq.delete();
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("abort_no_done", 64'(seen), 64'd0);
      issue("add_after_rst", 32'd2, 32'd2, 3'd3);
      wait_done(0);
      chk("add_after_rst_const", out, 64'd4);

      chk("sb_drained", 64'(sbq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU that replaces the combinational datapath ALU in the microprocessor execute stage. Operands and opcode are latched on a start strobe. Single-cycle ops return a registered result one cycle later. MUL runs an iterative shift-add over WIDTH cycles. Result and a full flag set (zero, carry, negative, overflow) are held stable until the next accepted start; the control unit sequences on `busy`/`done`.

## Interface
- `WIDTH`, 32, operand width; result width is 2*WIDTH; must be ≥ 4 and a power of two.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `start`  in  1  request strobe; accepted only when `busy`=0.
- `A`, `B`  in  WIDTH each  unsigned operands; sampled on the accepting edge.
- `Sel`  in  3  opcode: 0 MUL, 1 SRL, 2 XOR, 3 ADD, 4 SUB, 5 OR, 6 AND, 7 SHL.
- `busy`  out  1  high while an op is in flight.
- `done`  out  1  one-cycle pulse; result/flags valid from this cycle.
- `Out`  out  2*WIDTH  result.
- `zero_flag`, `carry_flag`, `neg_flag`, `ovf_flag`  out  1 each  status.

## Operation
- FSM states: IDLE, MUL, DONE. Reset → IDLE.
- IDLE + `start`: latch A, B, Sel; `busy`←1.
  - Sel≠0: compute into the result register → DONE.
  - Sel=0: load multiplier (B), clear accumulator, count←0 → MUL.
- MUL: one bit per cycle. If multiplier LSB=1, accumulator += A << count. Multiplier >>1; count++. After WIDTH iterations → DONE.
- DONE: `done`=1 for exactly one cycle, `busy`←0 → IDLE.
- `start` while `busy`=1 is ignored: no queueing and no operand re-latch.
- Arithmetic, all zero-extended to 2*WIDTH unless stated:
  - ADD: A+B.
  - SUB: (A−B) mod 2^(2*WIDTH), so the upper bits fill with 1s on borrow.
  - OR/AND/XOR: bitwise, upper half 0.
  - SHL: {0,A} << B.
  - SRL: {0,A} >> B.
  - Shift amount ≥ 2*WIDTH gives 0.
  - MUL: full unsigned 2*WIDTH product.
- Flags, registered with Out:
  - zero = (Out==0).
  - neg = Out[2*WIDTH−1].
  - carry: ADD gives the carry out of bit WIDTH−1; SUB gives the borrow (A<B); SHL gives 1 if any bit of A was shifted past bit 2*WIDTH−1; otherwise 0.
  - ovf: signed WIDTH-bit overflow for ADD and SUB only; otherwise 0.
- Out and flags hold their last value through IDLE and the next op until that op's DONE. They are not updated mid-MUL.
- Reset (asynchronous, any state, including mid-MUL): FSM→IDLE; Out, all flags, `busy`, `done`, and the internal accumulator/count all go to 0. The aborted op produces no `done`.

## Timing
- Accepting edge is edge k: `start`=1 sampled with `busy`=0.
- Non-MUL ops: after edge k+1, `done`=1 and Out/flags are valid. `busy`=1 only between edges k and k+1.
- MUL: `done` after edge k+WIDTH+1; `busy`=1 for WIDTH+1 cycles.
- Back-to-back issue: `start` may be reasserted in the DONE cycle but is ignored. The earliest accepted restart is the cycle after DONE, giving a throughput of one single-cycle op per 2 cycles.
- No combinational path from inputs to any output.

## Structure
- Package `alu_pkg`:
  - opcode localparams (OP_MUL … OP_SHL, values 0–7);
  - FSM state enum (IDLE, MUL, DONE);
  - flag-index constants for a future packed status bus.
- Sub-module `alu_mul_iter`:
  - shift-add multiplier with load/step/finish;
  - count width clog2(WIDTH)+1.
- Top level holds the FSM, the single-cycle datapath and the flag logic.

## Test plan
- Reset then ADD, WIDTH=32: A=0xFFFFFFFF, B=1 → done at k+1; Out=0x1_0000_0000, carry=1, zero=0, ovf=0.
- SUB: A=3, B=5 → Out=0xFFFF_FFFF_FFFF_FFFE, neg=1, carry=1. SUB with A=B=7 → Out=0, zero=1.
- ADD signed overflow: A=0x7FFFFFFF, B=1 → ovf=1, carry=0.
- MUL: A=0xFFFFFFFF, B=0xFFFFFFFF → done exactly 33 cycles after the accepting edge; Out=0xFFFFFFFE_00000001. A `start` issued mid-op with other operands is ignored.
- Shifts: SHL A=0x80000001, B=33 → Out=0x2_0000_0000, carry=1. SRL B=64 → Out=0, zero=1.
- Reset asserted at MUL cycle 10 → outputs 0 immediately, no `done`. A fresh ADD 2+2 then completes normally with Out=4.
